// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one mem_interface between the
// instruction-fetch port (0) and the data port (1) of a BRISC-V core.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   req/we/addr/wdata 0,1      requests from fetch (0) and data (1) ports
//   gnt0/gnt1                  one-cycle pulse: request accepted
//   done0/done1                one-cycle pulse: access complete
//   rdata                      read data, valid with done for a read
//   mem_read/mem_write         command strobes to mem_interface
//   mem_address/mem_in_data    command address and write data
//   mem_out_addr/mem_out_data  tagged read return from mem_interface
//   mem_valid/mem_ready        return valid / command ready
//
// Configuration macro: MEM_ARB_FIXED_PRIORITY_EN
//   defined   -> port 1 always wins a tie (no round-robin state)
//   undefined -> round-robin between the two ports (default)
module mem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req0,
    input  logic                    we0,
    input  logic [ADDRESS_BITS-1:0] addr0,
    input  logic [DATA_WIDTH-1:0]   wdata0,
    input  logic                    req1,
    input  logic                    we1,
    input  logic [ADDRESS_BITS-1:0] addr1,
    input  logic [DATA_WIDTH-1:0]   wdata1,
    output logic                    gnt0,
    output logic                    gnt1,
    output logic                    done0,
    output logic                    done1,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDRESS_BITS-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]   mem_in_data,
    input  logic [ADDRESS_BITS-1:0] mem_out_addr,
    input  logic [DATA_WIDTH-1:0]   mem_out_data,
    input  logic                    mem_valid,
    input  logic                    mem_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    port_q, port_d;
    logic                    we_q, we_d;
    logic [ADDRESS_BITS-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    gnt0_q, gnt0_d;
    logic                    gnt1_q, gnt1_d;
    logic                    done0_q, done0_d;
    logic                    done1_q, done1_d;
    logic                    mem_read_q, mem_read_d;
    logic                    mem_write_q, mem_write_d;
    logic                    win;

`ifndef MEM_ARB_FIXED_PRIORITY_EN
    // Port that won the most recent grant; the other one wins a tie.
    logic                    last_q, last_d;
`endif

    // Winner: a lone requester always wins; ties go by priority mode.
    always_comb begin
        win = req1;
        if (req0 && req1) begin
`ifdef MEM_ARB_FIXED_PRIORITY_EN
            win = 1'b1;
`else
            win = ~last_q;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
        last_d      = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (mem_ready && (req0 || req1)) begin
                    port_d      = win;
                    we_d        = win ? we1 : we0;
                    addr_d      = win ? addr1 : addr0;
                    wdata_d     = win ? wdata1 : wdata0;
                    gnt0_d      = ~win;
                    gnt1_d      = win;
                    mem_write_d = win ? we1 : we0;
                    mem_read_d  = win ? ~we1 : ~we0;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
                    last_d      = win;
`endif
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    // Writes need no return data: complete next cycle.
                    done0_d = ~port_q;
                    done1_d = port_q;
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Returns tagged with another address are not ours.
                if (mem_valid && (mem_out_addr == addr_q)) begin
                    rdata_d = mem_out_data;
                    done0_d = ~port_q;
                    done1_d = port_q;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            port_q      <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
            last_q      <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            port_q      <= port_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
            last_q      <= last_d;
`endif
        end
    end

    assign gnt0        = gnt0_q;
    assign gnt1        = gnt1_q;
    assign done0       = done0_q;
    assign done1       = done1_q;
    assign rdata       = rdata_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_address = addr_q;
    assign mem_in_data = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: randomized requests, a reactive
// memory model, and a monitor comparing grants/completions in order.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, we0 = 1'b0;
    logic        req1 = 1'b0, we1 = 1'b0;
    logic [19:0] addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, done0, done1;
    logic [31:0] rdata;
    logic        mem_read, mem_write;
    logic [19:0] mem_address;
    logic [31:0] mem_in_data;
    logic [19:0] mem_out_addr = '0;
    logic [31:0] mem_out_data = '0;
    logic        mem_valid = 1'b0;
    logic        mem_ready = 1'b1;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_in_data(mem_in_data),
        .mem_out_addr(mem_out_addr), .mem_out_data(mem_out_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          port;
        bit          we;
        logic [19:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    txn_t        gq[$];
    txn_t        dq[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          gnt_cyc = 0;
    int          valid_cyc = 0;
    bit          resp_hold = 1'b0;
    logic [31:0] ref_mem [16];
    logic [31:0] resp_mem [16];
    logic [31:0] model_rdata = '0;
    bit          ref_last = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    // Reference arbitration rule.
    function automatic bit pick(input bit r0, input bit r1);
        if (r0 && r1) begin
`ifdef MEM_ARB_FIXED_PRIORITY_EN
            return 1'b1;
`else
            return ~ref_last;
`endif
        end
        return r1;
    endfunction

    // Decide the winner and push what the DUT must do for it.
    task automatic expect_txn(input bit r0, input bit r1,
                              input bit w0, input bit w1,
                              input logic [19:0] a0, input logic [19:0] a1,
                              input logic [31:0] d0, input logic [31:0] d1);
        txn_t t;
        bit   w;
        w        = pick(r0, r1);
        ref_last = w;
        t.port   = w;
        t.we     = w ? w1 : w0;
        t.addr   = w ? a1 : a0;
        t.wdata  = w ? d1 : d0;
        if (t.we) ref_mem[t.addr[3:0]] = t.wdata;
        else model_rdata = ref_mem[t.addr[3:0]];
        t.rdata = model_rdata;
        gq.push_back(t);
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(gnt0 || gnt1) && n < 30);
        if (!(gnt0 || gnt1)) gq.delete();
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(done0 || done1) && n < 30);
        chk("done_seen", done0 || done1, 1);
        if (!(done0 || done1)) dq.delete();
    endtask

    task automatic run_txn(input bit r0, input bit r1,
                           input bit w0, input bit w1,
                           input logic [19:0] a0, input logic [19:0] a1,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input int stall);
        int n;
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        if (stall > 0) begin
            mem_ready = 1'b0;
            repeat (stall) begin
                @(negedge clk);
                chk("stall_quiet", {gnt0, gnt1, mem_read, mem_write}, 0);
            end
            mem_ready = 1'b1;
        end
        expect_txn(r0, r1, w0, w1, a0, a1, d0, d1);
        wait_gnt(n);
        chk("gnt_latency", n, 1);
        req0 = 1'b0; req1 = 1'b0;
        addr0 = 20'($urandom); addr1 = 20'($urandom);
        wdata0 = $urandom; wdata1 = $urandom;
        wait_done();
        @(negedge clk);
    endtask

    // Monitor: in-order comparison against the scoreboard queues.
    initial begin
        txn_t t;
        forever begin
            @(negedge clk);
            if (gnt0 && gnt1) chk("gnt_onehot", 2'b11, 2'b01);
            if ((mem_read || mem_write) && !(gnt0 || gnt1))
                chk("strobe_without_gnt", 1, 0);
            if (gnt0 || gnt1) begin
                if (gq.size() == 0) begin
                    chk("unexpected_gnt", {gnt0, gnt1}, 0);
                end else begin
                    t = gq.pop_front();
                    gnt_cyc = cyc;
                    chk("gnt_port", gnt1, t.port);
                    chk("mem_write", mem_write, t.we);
                    chk("mem_read", mem_read, !t.we);
                    chk("mem_address", mem_address, t.addr);
                    if (t.we) chk("mem_in_data", mem_in_data, t.wdata);
                    dq.push_back(t);
                end
            end
            if (done0 || done1) begin
                if (dq.size() == 0) begin
                    chk("unexpected_done", {done0, done1}, 0);
                end else begin
                    t = dq.pop_front();
                    chk("done_port", done1, t.port);
                    chk("done_onehot", done0 ^ done1, 1);
                    chk("rdata", rdata, t.rdata);
                    if (t.we) chk("wr_done_lat", cyc, gnt_cyc + 1);
                    else chk("rd_done_lat", cyc, valid_cyc + 1);
                end
            end
        end
    end

    // Memory model: random latency, sometimes a foreign-tagged return.
    initial begin
        logic [19:0] a;
        int          lat;
        bit          spur;
        forever begin
            @(negedge clk);
            mem_valid = 1'b0;
            if (mem_write) resp_mem[mem_address[3:0]] = mem_in_data;
            if (mem_read) begin
                if (resp_hold) begin
                    while (resp_hold) @(negedge clk);
                end else begin
                    a    = mem_address;
                    lat  = $urandom_range(1, 4);
                    spur = ($urandom_range(0, 1) == 1) && lat > 1;
                    for (int i = 1; i <= lat; i++) begin
                        @(negedge clk);
                        if (i == lat) begin
                            mem_valid    = 1'b1;
                            mem_out_addr = a;
                            mem_out_data = resp_mem[a[3:0]];
                            valid_cyc    = cyc;
                        end else if (spur && i == 1) begin
                            mem_valid    = 1'b1;
                            mem_out_addr = a ^ 20'hc;
                            mem_out_data = ~resp_mem[a[3:0]];
                        end else begin
                            mem_valid = 1'b0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        int n;
        int prev;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i]  = 32'ha5a50000 | i;
            resp_mem[i] = 32'ha5a50000 | i;
        end
        ref_mem[4]  = 32'h2;
        resp_mem[4] = 32'h2;

        repeat (3) @(negedge clk);
        chk("rst_strobes",
            {gnt0, gnt1, done0, done1, mem_read, mem_write}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_wdata", mem_in_data, 0);
        reset = 1'b1;
        @(negedge clk);

        // Write on port 1, then read on port 0 returning 0x2.
        run_txn(0, 1, 0, 1, 20'h0, 20'h2, 0, 32'h8, 0);
        run_txn(1, 0, 0, 0, 20'h4, 20'h0, 0, 0, 0);

        // Held tie: grant order and write-to-write spacing.
        req0 = 1'b1; we0 = 1'b1; addr0 = 20'h6; wdata0 = 32'h60;
        req1 = 1'b1; we1 = 1'b1; addr1 = 20'h7; wdata1 = 32'h70;
        for (int k = 0; k < 4; k++)
            expect_txn(1, 1, 1, 1, 20'h6, 20'h7, 32'h60, 32'h70);
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(n);
            chk("tie_gnt_seen", gnt0 || gnt1, 1);
            if (k == 0) chk("tie_first_lat", n, 1);
            else chk("tie_spacing", cyc - prev, 3);
            prev = cyc;
            if (k == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        wait_done();
        @(negedge clk);

        // Backpressure for 5 cycles.
        run_txn(1, 0, 1, 0, 20'h3, 20'h0, 32'h33, 0, 5);

        // Randomized traffic.
        for (int k = 0; k < 60; k++) begin
            bit r0, r1;
            r0 = 1'($urandom);
            r1 = 1'($urandom);
            if (!r0 && !r1) r0 = 1'b1;
            run_txn(r0, r1, 1'($urandom), 1'($urandom),
                    20'($urandom_range(0, 15)), 20'($urandom_range(0, 15)),
                    $urandom, $urandom,
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
        end

        // Reset while waiting for read data.
        resp_hold = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 20'h5;
        expect_txn(1, 0, 0, 0, 20'h5, 0, 0, 0);
        wait_gnt(n);
        chk("abort_gnt_lat", n, 1);
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_strobes",
            {gnt0, gnt1, done0, done1, mem_read, mem_write}, 0);
        chk("abort_rdata", rdata, 0);
        chk("abort_addr", mem_address, 0);
        dq.delete();
        ref_last    = 1'b1;
        model_rdata = '0;
        repeat (3) @(negedge clk);
        reset     = 1'b1;
        resp_hold = 1'b0;
        repeat (3) @(negedge clk);
        repeat (4) @(negedge clk);
        chk("abort_no_done", dq.size(), 0);
        run_txn(1, 0, 0, 0, 20'h5, 0, 0, 0, 0);
        run_txn(1, 1, 1, 0, 20'h9, 20'h9, 32'h99, 0, 0);
        run_txn(0, 1, 0, 0, 0, 20'h9, 0, 0, 0);

        chk("gq_empty", gq.size(), 0);
        chk("dq_empty", dq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
